// File: rtl/axi2mem_synch_join.sv
// ---------------------------------------------------------------------------
// axi2mem_synch_join
//
// N-channel synchronisation join for the axi2mem TCDM path. Every channel
// posts transaction IDs into its own circular FIFO. Once all channels hold at
// least one entry, a single joined request is presented downstream. It carries
// channel 0's head ID. An accepted join pops every channel together.
//
// Ports
//   clk_i               clock, all state updates on the rising edge
//   rst_i               synchronous reset, active-high
//   synch_req_i         [N_CH]            per-channel push request
//   synch_id_i          [N_CH*ID_WIDTH]   per-channel ID, channel c at c*ID_WIDTH
//   synch_ready_o       [N_CH]            per-channel FIFO not full (low in reset)
//   synch_level_o       [N_CH*LW]         per-channel occupancy, LW=$clog2(DEPTH+1)
//   synch_req_o                           joined request valid
//   synch_id_o          [ID_WIDTH]        head ID of channel 0
//   synch_gnt_i                           downstream accept
//   synch_err_o                           heads differ while synch_req_o=1
//   synch_err_sticky_o                    an accepted join had mismatched heads
// ---------------------------------------------------------------------------
module axi2mem_synch_join #(
    parameter int unsigned N_CH     = 2,
    parameter int unsigned ID_WIDTH = 6,
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned CHECK_ID = 1
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [N_CH-1:0]                    synch_req_i,
    input  logic [N_CH*ID_WIDTH-1:0]           synch_id_i,
    output logic [N_CH-1:0]                    synch_ready_o,
    output logic [N_CH*$clog2(DEPTH+1)-1:0]    synch_level_o,
    output logic                               synch_req_o,
    output logic [ID_WIDTH-1:0]                synch_id_o,
    input  logic                               synch_gnt_i,
    output logic                               synch_err_o,
    output logic                               synch_err_sticky_o
);

    localparam int unsigned LW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    logic [ID_WIDTH-1:0] mem_q  [N_CH][DEPTH];
    logic [PW-1:0]       rptr_q [N_CH];
    logic [PW-1:0]       wptr_q [N_CH];
    logic [LW-1:0]       cnt_q  [N_CH];
    logic                err_sticky_q;

    logic [N_CH-1:0]     push;
    logic [ID_WIDTH-1:0] head [N_CH];
    logic                join_req;
    logic                pop;
    logic                err;

    // Ready looks at the registered count only, so a full FIFO refuses a push
    // even in a cycle where the join pops it.
    always_comb begin
        join_req = 1'b1;
        push     = '0;
        for (int unsigned c = 0; c < N_CH; c++) begin
            head[c]          = mem_q[c][rptr_q[c]];
            synch_ready_o[c] = (cnt_q[c] != FULL) & ~rst_i;
            push[c]          = synch_req_i[c] & synch_ready_o[c];
            join_req         = join_req & (cnt_q[c] != '0);
        end
    end

    assign pop = join_req & synch_gnt_i;

    generate
        if (CHECK_ID != 0) begin : g_check
            logic mism;
            always_comb begin
                mism = 1'b0;
                for (int unsigned c = 1; c < N_CH; c++) begin
                    mism = mism | (head[c] != head[0]);
                end
            end
            assign err = join_req & mism;
        end else begin : g_nocheck
            assign err = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned c = 0; c < N_CH; c++) begin
                rptr_q[c] <= '0;
                wptr_q[c] <= '0;
                cnt_q[c]  <= '0;
                for (int unsigned e = 0; e < DEPTH; e++) begin
                    mem_q[c][e] <= '0;
                end
            end
            err_sticky_q <= 1'b0;
        end else begin
            for (int unsigned c = 0; c < N_CH; c++) begin
                if (push[c]) begin
                    mem_q[c][wptr_q[c]] <= synch_id_i[c*ID_WIDTH +: ID_WIDTH];
                    wptr_q[c]           <= wptr_q[c] + PW'(1);
                end
                if (pop) begin
                    rptr_q[c] <= rptr_q[c] + PW'(1);
                end
                case ({push[c], pop})
                    2'b10:   cnt_q[c] <= cnt_q[c] + LW'(1);
                    2'b01:   cnt_q[c] <= cnt_q[c] - LW'(1);
                    default: cnt_q[c] <= cnt_q[c];
                endcase
            end
            if (err & synch_gnt_i) begin
                err_sticky_q <= 1'b1;
            end
        end
    end

    always_comb begin
        synch_level_o = '0;
        for (int unsigned c = 0; c < N_CH; c++) begin
            synch_level_o[c*LW +: LW] = cnt_q[c];
        end
    end

    assign synch_req_o        = join_req;
    assign synch_id_o         = head[0];
    assign synch_err_o        = err;
    assign synch_err_sticky_o = err_sticky_q;

endmodule

// File: tb/tb_axi2mem_synch_join.sv
module tb_axi2mem_synch_join;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 2-channel, depth-2 instance for directed tests
    logic [1:0]  a_req;
    logic [11:0] a_id;
    logic [1:0]  a_rdy;
    logic [3:0]  a_lvl;
    logic        a_req_o;
    logic [5:0]  a_id_o;
    logic        a_gnt, a_err, a_sticky;

    // 4-channel, depth-4 instance for the randomized run
    logic [3:0]  b_req;
    logic [31:0] b_id;
    logic [3:0]  b_rdy;
    logic [11:0] b_lvl;
    logic        b_req_o;
    logic [7:0]  b_id_o;
    logic        b_gnt, b_err, b_sticky;

    axi2mem_synch_join #(.N_CH(2), .ID_WIDTH(6), .DEPTH(2), .CHECK_ID(1)) dut2 (
        .clk_i(clk), .rst_i(rst),
        .synch_req_i(a_req), .synch_id_i(a_id),
        .synch_ready_o(a_rdy), .synch_level_o(a_lvl),
        .synch_req_o(a_req_o), .synch_id_o(a_id_o), .synch_gnt_i(a_gnt),
        .synch_err_o(a_err), .synch_err_sticky_o(a_sticky)
    );

    axi2mem_synch_join #(.N_CH(4), .ID_WIDTH(8), .DEPTH(4), .CHECK_ID(1)) dut4 (
        .clk_i(clk), .rst_i(rst),
        .synch_req_i(b_req), .synch_id_i(b_id),
        .synch_ready_o(b_rdy), .synch_level_o(b_lvl),
        .synch_req_o(b_req_o), .synch_id_o(b_id_o), .synch_gnt_i(b_gnt),
        .synch_err_o(b_err), .synch_err_sticky_o(b_sticky)
    );

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_drive(input logic [1:0] req, input logic [5:0] id0, input logic [5:0] id1);
        a_req = req;
        a_id  = {id1, id0};
    endtask

    // reference model for the 4-channel run: one queue of IDs per channel
    logic [7:0] seq [4096];
    logic [7:0] mq [4][$];
    int         idx [4];
    int         njoin;
    logic       exp_req, do_pop;
    logic [3:0] acc;

    initial begin
        rst = 1'b1;
        a_drive(2'b11, 6'h3F, 6'h3F);
        a_gnt = 1'b0;
        b_req = '0; b_id = '0; b_gnt = 1'b0;

        // ---- reset / idle
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("rst_ready", a_rdy, 2'b00);
            check_eq("rst_level", a_lvl, 4'h0);
            check_eq("rst_req", a_req_o, 1'b0);
            check_eq("rst_id", a_id_o, 6'h00);
            check_eq("rst4_ready", b_rdy, 4'h0);
        end
        a_drive(2'b00, 6'h00, 6'h00);
        rst = 1'b0;
        #1;
        check_eq("rel_ready", a_rdy, 2'b11);
        tick();
        check_eq("rel_req", a_req_o, 1'b0);

        // ---- basic join
        a_gnt = 1'b1;
        a_drive(2'b01, 6'h05, 6'h00);
        tick();
        a_drive(2'b00, 6'h00, 6'h00);
        check_eq("bj_lvl1", a_lvl, 4'b0001);
        check_eq("bj_noreq1", a_req_o, 1'b0);
        tick();
        check_eq("bj_noreq2", a_req_o, 1'b0);
        tick();
        check_eq("bj_noreq3", a_req_o, 1'b0);
        a_drive(2'b10, 6'h00, 6'h05);
        tick();
        a_drive(2'b00, 6'h00, 6'h00);
        check_eq("bj_req", a_req_o, 1'b1);
        check_eq("bj_id", a_id_o, 6'h05);
        check_eq("bj_err", a_err, 1'b0);
        check_eq("bj_lvl2", a_lvl, 4'b0101);
        tick();
        check_eq("bj_pop_req", a_req_o, 1'b0);
        check_eq("bj_pop_lvl", a_lvl, 4'b0000);

        // ---- backpressure
        a_gnt = 1'b0;
        a_drive(2'b01, 6'h01, 6'h00);
        tick();
        check_eq("bp_lvl1", a_lvl, 4'b0001);
        check_eq("bp_rdy1", a_rdy, 2'b11);
        a_drive(2'b01, 6'h02, 6'h00);
        tick();
        check_eq("bp_rdy2", a_rdy, 2'b10);
        check_eq("bp_lvl2", a_lvl, 4'b0010);
        a_drive(2'b01, 6'h03, 6'h00);
        tick();
        check_eq("bp_drop_lvl", a_lvl, 4'b0010);
        check_eq("bp_drop_req", a_req_o, 1'b0);
        a_gnt = 1'b1;
        a_drive(2'b10, 6'h00, 6'h01);
        tick();
        check_eq("bp_j1_req", a_req_o, 1'b1);
        check_eq("bp_j1_id", a_id_o, 6'h01);
        check_eq("bp_j1_lvl", a_lvl, 4'b0110);
        a_drive(2'b10, 6'h00, 6'h02);
        tick();
        a_drive(2'b00, 6'h00, 6'h00);
        check_eq("bp_j2_req", a_req_o, 1'b1);
        check_eq("bp_j2_id", a_id_o, 6'h02);
        check_eq("bp_j2_lvl", a_lvl, 4'b0101);
        tick();
        check_eq("bp_end_req", a_req_o, 1'b0);
        check_eq("bp_end_lvl", a_lvl, 4'b0000);

        // ---- stall with full FIFOs
        a_gnt = 1'b0;
        a_drive(2'b11, 6'h0A, 6'h0A);
        tick();
        a_drive(2'b11, 6'h0B, 6'h0B);
        tick();
        check_eq("st_req", a_req_o, 1'b1);
        check_eq("st_id", a_id_o, 6'h0A);
        check_eq("st_rdy", a_rdy, 2'b00);
        check_eq("st_lvl", a_lvl, 4'b1010);
        a_drive(2'b11, 6'h3F, 6'h3F);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("st_hold_req", a_req_o, 1'b1);
            check_eq("st_hold_id", a_id_o, 6'h0A);
            check_eq("st_hold_lvl", a_lvl, 4'b1010);
        end
        a_gnt = 1'b1;
        tick();
        check_eq("st_g1_req", a_req_o, 1'b1);
        check_eq("st_g1_id", a_id_o, 6'h0B);
        check_eq("st_g1_lvl", a_lvl, 4'b0101);
        a_drive(2'b00, 6'h00, 6'h00);
        tick();
        check_eq("st_g2_req", a_req_o, 1'b0);
        check_eq("st_g2_lvl", a_lvl, 4'b0000);

        // ---- ID mismatch
        a_gnt = 1'b0;
        a_drive(2'b11, 6'h11, 6'h12);
        tick();
        a_drive(2'b00, 6'h00, 6'h00);
        check_eq("mm_req", a_req_o, 1'b1);
        check_eq("mm_err", a_err, 1'b1);
        check_eq("mm_sticky0", a_sticky, 1'b0);
        tick();
        check_eq("mm_err_hold", a_err, 1'b1);
        check_eq("mm_sticky_hold", a_sticky, 1'b0);
        a_gnt = 1'b1;
        tick();
        check_eq("mm_sticky1", a_sticky, 1'b1);
        check_eq("mm_err_clr", a_err, 1'b0);
        check_eq("mm_req_clr", a_req_o, 1'b0);
        a_drive(2'b11, 6'h07, 6'h07);
        tick();
        a_drive(2'b00, 6'h00, 6'h00);
        check_eq("mm_ok_req", a_req_o, 1'b1);
        check_eq("mm_ok_id", a_id_o, 6'h07);
        check_eq("mm_ok_err", a_err, 1'b0);
        check_eq("mm_ok_sticky", a_sticky, 1'b1);
        tick();
        check_eq("mm_after_sticky", a_sticky, 1'b1);
        check_eq("mm_after_req", a_req_o, 1'b0);
        rst = 1'b1;
        tick();
        check_eq("mm_rst_sticky", a_sticky, 1'b0);
        rst = 1'b0;
        a_gnt = 1'b0;

        // ---- randomized 4-channel run
        for (int i = 0; i < 4096; i++) seq[i] = 8'($urandom);
        for (int c = 0; c < 4; c++) begin
            idx[c] = 0;
            mq[c].delete();
        end
        njoin = 0;
        tick();
        for (int cyc = 0; cyc < 2012; cyc++) begin
            exp_req = 1'b1;
            for (int c = 0; c < 4; c++) begin
                if (mq[c].size() == 0) exp_req = 1'b0;
                check_eq("r_ready", b_rdy[c], (mq[c].size() != 4));
                check_eq("r_level", b_lvl[c*3 +: 3], mq[c].size());
            end
            check_eq("r_req", b_req_o, exp_req);
            if (exp_req) check_eq("r_id", b_id_o, mq[0][0]);
            check_eq("r_err", b_err, 1'b0);
            check_eq("r_sticky", b_sticky, 1'b0);

            for (int c = 0; c < 4; c++) begin
                b_req[c] = (cyc < 2000) ? ($urandom_range(0, 3) != 0) : 1'b0;
                b_id[c*8 +: 8] = seq[idx[c]];
            end
            b_gnt = (cyc < 2000) ? ($urandom_range(0, 2) != 0) : 1'b1;

            do_pop = exp_req & b_gnt;
            for (int c = 0; c < 4; c++) acc[c] = b_req[c] && (mq[c].size() < 4);
            if (do_pop) begin
                check_eq("r_seq", b_id_o, seq[njoin]);
                njoin++;
                for (int c = 0; c < 4; c++) void'(mq[c].pop_front());
            end
            for (int c = 0; c < 4; c++) begin
                if (acc[c]) begin
                    mq[c].push_back(seq[idx[c]]);
                    idx[c]++;
                end
            end
            tick();
        end
        for (int c = 0; c < 4; c++) begin
            check_eq("r_final_lvl", b_lvl[c*3 +: 3], idx[c] - njoin);
        end
        check_eq("r_some_joins", (njoin > 100), 1'b1);
        check_eq("r_final_sticky", b_sticky, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
